// File: rtl/scorehand_acc.sv
// scorehand_acc -- per-hand running card scorer with end-of-round lock.
//
// Cards arrive one per cycle on card_valid, tagged with a hand index. Each
// hand keeps a registered running score (mod MOD), an accepted-card count and
// a sticky natural flag. A three-state FSM (IDLE/DEAL/LOCKED) detects the end
// of the round and then refuses all further cards until clear or reset.
//
// Ports:
//   slow_clock  sole clock, rising edge
//   reset       asynchronous, active-high; clears all state
//   clear       synchronous round clear (wins over a simultaneous card)
//   card_valid  card present this cycle
//   card_hand   target hand index [HW-1:0]
//   card        card code [CARD_W-1:0]; legal codes 1..13
//   score       per-hand score, hand i at [i*SCORE_W +: SCORE_W]
//   count       per-hand accepted card count, hand i at [i*CW +: CW]
//   natural     per-hand sticky natural flag
//   done        high while the FSM is LOCKED
//   err         one-cycle pulse the cycle after a rejected card
module scorehand_acc #(
    parameter int NUM_HANDS = 2,
    parameter int MAX_CARDS = 3,
    parameter int CARD_W    = 4,
    parameter int MOD       = 10,
    parameter int SCORE_W   = 4,
    localparam int HW = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
    localparam int CW = $clog2(MAX_CARDS + 1)
) (
    input  logic                         slow_clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         card_valid,
    input  logic [HW-1:0]                card_hand,
    input  logic [CARD_W-1:0]            card,
    output logic [NUM_HANDS*SCORE_W-1:0] score,
    output logic [NUM_HANDS*CW-1:0]      count,
    output logic [NUM_HANDS-1:0]         natural,
    output logic                         done,
    output logic                         err
);

    typedef enum logic [1:0] {IDLE, DEAL, LOCKED} state_t;

    state_t               state_r, state_n;
    logic [SCORE_W-1:0]   score_r [NUM_HANDS];
    logic [SCORE_W-1:0]   score_n [NUM_HANDS];
    logic [CW-1:0]        count_r [NUM_HANDS];
    logic [CW-1:0]        count_n [NUM_HANDS];
    logic [NUM_HANDS-1:0] nat_r, nat_n;
    logic                 card_ok;
    logic                 accept;
    logic                 err_n;
    logic                 all_full;
    logic                 all_two;

    // Face cards and tens count as zero.
    function automatic int card_value(input int code);
        return (code >= 1 && code <= 9) ? code : 0;
    endfunction

    // Both operands are below MOD, so a single conditional subtract wraps.
    function automatic logic [SCORE_W-1:0] mod_add(input logic [SCORE_W-1:0] a,
                                                   input int b);
        int s;
        s = int'(a) + b;
        if (s >= MOD) s = s - MOD;
        return SCORE_W'(s);
    endfunction

    always_comb begin
        card_ok = (card != '0) && (int'(card) <= 13);
        accept  = 1'b0;
        for (int h = 0; h < NUM_HANDS; h++) begin
            score_n[h] = score_r[h];
            count_n[h] = count_r[h];
            nat_n[h]   = nat_r[h];
            // An out-of-range hand index matches no hand and is therefore rejected.
            if (card_valid && !clear && card_ok && (state_r != LOCKED) &&
                (card_hand == HW'(h)) && (int'(count_r[h]) < MAX_CARDS)) begin
                accept     = 1'b1;
                score_n[h] = mod_add(score_r[h], card_value(int'(card)));
                count_n[h] = count_r[h] + CW'(1);
                if ((int'(count_n[h]) == 2) && (int'(score_n[h]) >= MOD - 2))
                    nat_n[h] = 1'b1;
            end
        end

        // Lock decisions look at the post-update counts and flags.
        all_full = 1'b1;
        all_two  = 1'b1;
        for (int h = 0; h < NUM_HANDS; h++) begin
            if (int'(count_n[h]) != MAX_CARDS) all_full = 1'b0;
            if (int'(count_n[h]) < 2)          all_two  = 1'b0;
        end

        state_n = state_r;
        case (state_r)
            IDLE:    if (accept) state_n = DEAL;
            DEAL:    if (all_full || ((|nat_n) && all_two)) state_n = LOCKED;
            LOCKED:  state_n = LOCKED;
            default: state_n = IDLE;
        endcase

        err_n = card_valid && !clear && !accept;
    end

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            for (int h = 0; h < NUM_HANDS; h++) begin
                score_r[h] <= '0;
                count_r[h] <= '0;
            end
            nat_r   <= '0;
            state_r <= IDLE;
            err     <= 1'b0;
        end else if (clear) begin
            for (int h = 0; h < NUM_HANDS; h++) begin
                score_r[h] <= '0;
                count_r[h] <= '0;
            end
            nat_r   <= '0;
            state_r <= IDLE;
            err     <= 1'b0;
        end else begin
            for (int h = 0; h < NUM_HANDS; h++) begin
                score_r[h] <= score_n[h];
                count_r[h] <= count_n[h];
            end
            nat_r   <= nat_n;
            state_r <= state_n;
            err     <= err_n;
        end
    end

    always_comb begin
        for (int h = 0; h < NUM_HANDS; h++) begin
            score[h*SCORE_W +: SCORE_W] = score_r[h];
            count[h*CW +: CW]           = count_r[h];
        end
    end

    assign natural = nat_r;
    assign done    = (state_r == LOCKED);

endmodule
